// File: rtl/graphics_mem_pkg.sv
// Shared types and widths for the graphics/CPU SDRAM front-end.
package graphics_mem_pkg;

    localparam int SDRAM_AW = 26;
    localparam int BURST_LW = 11;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_CROM = 2'd0,
        REQ_SROM = 2'd1,
        REQ_PROM = 2'd2
    } req_id_t;

endpackage

// File: rtl/arb_priority_select.sv
// Combinational winner pick: a starved requester (age == AGE_MAX) pre-empts fixed priority 0 > 1 > 2.
module arb_priority_select #(
    parameter int NREQ    = 3,
    parameter int AGE_MAX = 4,
    parameter int AGE_W   = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0][AGE_W-1:0] age,
    output logic [NREQ-1:0]            grant,
    output logic [IDX_W-1:0]           winner
);

    logic [NREQ-1:0] aged_s;
    logic [NREQ-1:0] cand_s;
    logic            found_s;

    // Lowest-index candidate from the starved set, or from all requesters when none are starved.
    always_comb begin
        aged_s  = '0;
        cand_s  = '0;
        found_s = 1'b0;
        winner  = '0;
        grant   = '0;
        for (int i = 0; i < NREQ; i++) begin
            aged_s[i] = req[i] && (age[i] == AGE_W'(AGE_MAX));
        end
        if (|aged_s) begin
            cand_s = aged_s;
        end else begin
            cand_s = req;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (cand_s[i] && !found_s) begin
                found_s = 1'b1;
                winner  = IDX_W'(i);
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            grant = {{(NREQ-1){1'b0}}, 1'b1} << winner;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/burst_port_arbiter.sv
// Shares the SDRAM burst-read port between CROM, SROM and P-ROM fetchers, one burst at a time.
// Optional burst abort on missing completion: define BURST_ARB_TIMEOUT_EN.
module burst_port_arbiter
    import graphics_mem_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int AGE_MAX = 4
`ifdef BURST_ARB_TIMEOUT_EN
    , parameter int TIMEOUT = 512
`endif
) (
    input  logic                          sdram_clk,
    input  logic                          RESET,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0][SDRAM_AW-1:0] req_addr,
    input  logic [NREQ-1:0][BURST_LW-1:0] req_len,
    input  logic [NREQ-1:0]               req_32bit,
    output logic [NREQ-1:0]               ack,
    output logic [NREQ-1:0]               rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic [NREQ-1:0]               rd_done,
    output logic [NREQ-1:0]               rd_err,
    output logic                          burst_rd,
    output logic [SDRAM_AW-1:0]           burst_addr,
    output logic [BURST_LW-1:0]           burst_len,
    output logic                          burst_32bit,
    input  logic [DATA_W-1:0]             burst_data,
    input  logic                          burst_data_valid,
    input  logic                          burst_data_done
);

    localparam int AGE_W = $clog2(AGE_MAX + 32'd1);
    localparam int IDX_W = $clog2(NREQ);

    arb_state_t                 state_r;
    arb_state_t                 state_s;
    logic [NREQ-1:0]            owner_r;
    logic [NREQ-1:0][AGE_W-1:0] age_r;
    logic [NREQ-1:0]            grant_s;
    logic [IDX_W-1:0]           winner_s;
    logic                       arb_s;
    logic                       in_wait_s;
    logic                       abort_s;

    assign arb_s     = (state_r == IDLE) && (|req);
    assign in_wait_s = (state_r == WAIT);

    arb_priority_select #(
        .NREQ    (NREQ),
        .AGE_MAX (AGE_MAX),
        .AGE_W   (AGE_W),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req    (req),
        .age    (age_r),
        .grant  (grant_s),
        .winner (winner_s)
    );

    // State register.
    always_ff @(posedge sdram_clk or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (|req) state_s = ISSUE; else state_s = IDLE;
            ISSUE:   state_s = WAIT;
            WAIT:    if (burst_data_done || abort_s) state_s = IDLE; else state_s = WAIT;
            default: state_s = IDLE;
        endcase
    end

    // Burst command, ownership and starvation ages; ages move only on an arbitration cycle.
    always_ff @(posedge sdram_clk or posedge RESET) begin
        if (RESET) begin
            burst_rd    <= 1'b0;
            burst_addr  <= '0;
            burst_len   <= BURST_LW'(2'd2);
            burst_32bit <= 1'b1;
            ack         <= '0;
            owner_r     <= '0;
            age_r       <= '0;
        end else begin
            burst_rd <= (state_r == ISSUE);
            ack      <= (state_r == ISSUE) ? owner_r : '0;
            if (arb_s) begin
                burst_addr  <= req_addr[winner_s];
                burst_len   <= req_len[winner_s];
                burst_32bit <= req_32bit[winner_s];
                owner_r     <= grant_s;
                for (int i = 0; i < NREQ; i++) begin
                    if (grant_s[i]) begin
                        age_r[i] <= '0;
                    end else if (req[i] && (age_r[i] != AGE_W'(AGE_MAX))) begin
                        age_r[i] <= age_r[i] + AGE_W'(1'b1);
                    end
                end
            end else if (in_wait_s && (burst_data_done || abort_s)) begin
                owner_r <= '0;
            end
        end
    end

    // Return-path steering; anything arriving outside WAIT is dropped.
    always_ff @(posedge sdram_clk or posedge RESET) begin
        if (RESET) begin
            rd_valid <= '0;
            rd_data  <= '0;
            rd_done  <= '0;
        end else begin
            rd_valid <= (in_wait_s && burst_data_valid) ? owner_r : '0;
            rd_done  <= (in_wait_s && burst_data_done) ? owner_r : '0;
            if (in_wait_s && burst_data_valid) begin
                rd_data <= burst_data;
            end
        end
    end

`ifdef BURST_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMO_W-1:0] tmo_cnt_r;

    assign abort_s = in_wait_s && !burst_data_done && (tmo_cnt_r == TMO_W'(TIMEOUT - 32'd1));

    // Cycles spent in WAIT for the current burst.
    always_ff @(posedge sdram_clk or posedge RESET) begin
        if (RESET) begin
            tmo_cnt_r <= '0;
        end else if (in_wait_s && !burst_data_done && !abort_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // Abort report to the owner of the stalled burst.
    always_ff @(posedge sdram_clk or posedge RESET) begin
        if (RESET) begin
            rd_err <= '0;
        end else begin
            rd_err <= abort_s ? owner_r : '0;
        end
    end
`else
    assign abort_s = 1'b0;
    assign rd_err  = '0;
`endif

endmodule

// File: tb/tb_burst_port_arbiter.sv
// Directed bench for burst_port_arbiter; returned words and completions are scoreboarded.
module tb_burst_port_arbiter;
    import graphics_mem_pkg::*;

    logic             sdram_clk = 1'b0;
    logic             RESET = 1'b1;
    logic [2:0]       req;
    logic [2:0][25:0] req_addr;
    logic [2:0][10:0] req_len;
    logic [2:0]       req_32bit;
    logic [2:0]       ack, rd_valid, rd_done, rd_err;
    logic [31:0]      rd_data;
    logic             burst_rd;
    logic [25:0]      burst_addr;
    logic [10:0]      burst_len;
    logic             burst_32bit;
    logic [31:0]      burst_data;
    logic             burst_data_valid, burst_data_done;

    typedef struct packed {
        logic [2:0]  owner;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] done_q[$];
    exp_t       mon_e;
    logic [2:0] mon_d;
    int         n_checks = 0;
    int         n_fails  = 0;

    always #5 sdram_clk = ~sdram_clk;

    burst_port_arbiter #(
        .NREQ    (3),
        .AGE_MAX (4)
`ifdef BURST_ARB_TIMEOUT_EN
        , .TIMEOUT (16)
`endif
    ) dut (
        .sdram_clk        (sdram_clk),
        .RESET            (RESET),
        .req              (req),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .req_32bit        (req_32bit),
        .ack              (ack),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .rd_done          (rd_done),
        .rd_err           (rd_err),
        .burst_rd         (burst_rd),
        .burst_addr       (burst_addr),
        .burst_len        (burst_len),
        .burst_32bit      (burst_32bit),
        .burst_data       (burst_data),
        .burst_data_valid (burst_data_valid),
        .burst_data_done  (burst_data_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic wait_issue(input string tag, input logic [2:0] a, input logic [25:0] addr,
                              input logic [10:0] len, input logic w32);
        int n = 0;
        while (burst_rd !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_burst_rd"}, burst_rd, 1'b1);
        check({tag, "_ack"}, ack, a);
        check({tag, "_addr"}, burst_addr, addr);
        check({tag, "_len"}, burst_len, len);
        check({tag, "_32bit"}, burst_32bit, w32);
    endtask

    task automatic send_words(input logic [2:0] owner, input int n, input logic [31:0] base, input bit done_last);
        for (int i = 0; i < n; i++) begin
            burst_data       = base + 32'(i);
            burst_data_valid = 1'b1;
            burst_data_done  = done_last && (i == n - 1);
            exp_q.push_back(exp_t'({owner, burst_data}));
            if (burst_data_done) done_q.push_back(owner);
            tick();
        end
        burst_data_valid = 1'b0;
        burst_data_done  = 1'b0;
    endtask

    task automatic send_done(input logic [2:0] owner);
        burst_data_done = 1'b1;
        done_q.push_back(owner);
        tick();
        burst_data_done = 1'b0;
    endtask

    // Scoreboard: each strobe must match the oldest outstanding expectation.
    always @(negedge sdram_clk) begin
        if (!RESET) begin
            if (|rd_valid) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("rd_valid_owner", rd_valid, mon_e.owner);
                    check("rd_data", rd_data, mon_e.data);
                end else begin
                    check("stray_rd_valid", rd_valid, 3'b000);
                end
            end
            if (|rd_done) begin
                if (done_q.size() > 0) begin
                    mon_d = done_q.pop_front();
                    check("rd_done_owner", rd_done, mon_d);
                end else begin
                    check("stray_rd_done", rd_done, 3'b000);
                end
            end
`ifndef BURST_ARB_TIMEOUT_EN
            if (|rd_err) check("rd_err_tied", rd_err, 3'b000);
`endif
        end
    end

    initial begin
        req              = 3'b000;
        req_addr         = '0;
        req_len          = '0;
        req_32bit        = 3'b000;
        burst_data       = 32'h0;
        burst_data_valid = 1'b0;
        burst_data_done  = 1'b0;
        tick();
        tick();
        check("rst_burst_rd", burst_rd, 1'b0);
        check("rst_addr", burst_addr, 26'h0);
        check("rst_len", burst_len, 11'd2);
        check("rst_32bit", burst_32bit, 1'b1);
        check("rst_ack", ack, 3'b000);
        check("rst_rd_valid", rd_valid, 3'b000);
        check("rst_rd_done", rd_done, 3'b000);
        check("rst_rd_err", rd_err, 3'b000);
        check("rst_rd_data", rd_data, 32'h0);
        RESET = 1'b0;
        tick();

        // 1: single CROM burst, latency and one-cycle issue pulse
        req_addr[REQ_CROM] = 26'h0123450;
        req_len[REQ_CROM]  = 11'd4;
        req_32bit[REQ_CROM] = 1'b1;
        req[REQ_CROM] = 1'b1;
        tick();
        check("t1_lat_n1", burst_rd, 1'b0);
        tick();
        check("t1_lat_n2", burst_rd, 1'b1);
        check("t1_ack", ack, 3'b001);
        check("t1_addr", burst_addr, 26'h0123450);
        check("t1_len", burst_len, 11'd4);
        req[REQ_CROM] = 1'b0;
        tick();
        check("t1_rd_pulse", burst_rd, 1'b0);
        check("t1_ack_pulse", ack, 3'b000);
        send_words(3'b001, 4, 32'hC0DE_0000, 1'b0);
        send_done(3'b001);
        tick();

        // 2: CROM beats PROM; PROM follows after one idle cycle
        req_addr[REQ_CROM] = 26'h0000100;
        req_len[REQ_CROM]  = 11'd2;
        req_32bit[REQ_CROM] = 1'b0;
        req_addr[REQ_PROM] = 26'h3FFFF00;
        req_len[REQ_PROM]  = 11'd3;
        req_32bit[REQ_PROM] = 1'b1;
        req = 3'b101;
        wait_issue("t2_crom", 3'b001, 26'h0000100, 11'd2, 1'b0);
        req[REQ_CROM] = 1'b0;
        send_words(3'b001, 2, 32'hA5A5_0000, 1'b1);
        check("t2_gap0", burst_rd, 1'b0);
        tick();
        check("t2_gap1", burst_rd, 1'b0);
        tick();
        check("t2_prom_rd", burst_rd, 1'b1);
        check("t2_prom_ack", ack, 3'b100);
        check("t2_prom_addr", burst_addr, 26'h3FFFF00);
        check("t2_prom_len", burst_len, 11'd3);
        check("t2_prom_32bit", burst_32bit, 1'b1);
        req[REQ_PROM] = 1'b0;
        tick();
        send_words(3'b100, 3, 32'h5A5A_0000, 1'b1);
        tick();

        // 3: starvation ageing of SROM against a continuous CROM request
        req_addr[REQ_SROM] = 26'h0004000;
        req_len[REQ_SROM]  = 11'd8;
        req_32bit[REQ_SROM] = 1'b0;
        req = 3'b011;
        for (int k = 1; k <= 6; k++) begin
            if (k == 5) begin
                wait_issue($sformatf("t3_arb%0d", k), 3'b010, 26'h0004000, 11'd8, 1'b0);
                tick();
                send_words(3'b010, 1, 32'h3300_0000 + 32'(k), 1'b1);
            end else begin
                wait_issue($sformatf("t3_arb%0d", k), 3'b001, 26'h0000100, 11'd2, 1'b0);
                tick();
                send_words(3'b001, 1, 32'h3300_0000 + 32'(k), 1'b1);
            end
        end
        req = 3'b000;
        tick();

        // 4: stray strobes while idle
        burst_data       = 32'hDEAD_BEEF;
        burst_data_valid = 1'b1;
        burst_data_done  = 1'b1;
        tick();
        burst_data_valid = 1'b0;
        burst_data_done  = 1'b0;
        tick();
        check("t4_rd_valid", rd_valid, 3'b000);
        check("t4_rd_done", rd_done, 3'b000);
        check("t4_rd_data_held", rd_data, 32'h3300_0006);
        req[REQ_PROM] = 1'b1;
        tick();
        check("t4_lat_n1", burst_rd, 1'b0);
        tick();
        check("t4_lat_n2", burst_rd, 1'b1);
        check("t4_ack", ack, 3'b100);
        req[REQ_PROM] = 1'b0;
        tick();
        send_words(3'b100, 1, 32'h4400_0001, 1'b1);
        tick();

        // 5: reset in the middle of a burst
        req_addr[REQ_CROM] = 26'h0123450;
        req_len[REQ_CROM]  = 11'd4;
        req_32bit[REQ_CROM] = 1'b1;
        req[REQ_CROM] = 1'b1;
        wait_issue("t5_crom", 3'b001, 26'h0123450, 11'd4, 1'b1);
        req[REQ_CROM] = 1'b0;
        send_words(3'b001, 2, 32'h5500_0000, 1'b0);
        tick();
        RESET = 1'b1;
        #1;
        check("t5_rst_burst_rd", burst_rd, 1'b0);
        check("t5_rst_addr", burst_addr, 26'h0);
        check("t5_rst_len", burst_len, 11'd2);
        check("t5_rst_32bit", burst_32bit, 1'b1);
        check("t5_rst_rd_data", rd_data, 32'h0);
        check("t5_rst_rd_valid", rd_valid, 3'b000);
        tick();
        RESET = 1'b0;
        tick();
        req_addr[REQ_SROM] = 26'h1234567;
        req_len[REQ_SROM]  = 11'd16;
        req_32bit[REQ_SROM] = 1'b1;
        req[REQ_SROM] = 1'b1;
        tick();
        check("t5_lat_n1", burst_rd, 1'b0);
        tick();
        check("t5_lat_n2", burst_rd, 1'b1);
        check("t5_ack", ack, 3'b010);
        check("t5_addr", burst_addr, 26'h1234567);
        check("t5_len", burst_len, 11'd16);
        req[REQ_SROM] = 1'b0;
        send_words(3'b010, 2, 32'h6600_0000, 1'b1);
        tick();

`ifdef BURST_ARB_TIMEOUT_EN
        // 6: missing completion aborts after 16 cycles; late strobes are dropped
        req[REQ_SROM] = 1'b1;
        wait_issue("t6_srom", 3'b010, 26'h1234567, 11'd16, 1'b1);
        req[REQ_SROM] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) check("t6_err_early", rd_err, 3'b000);
            if (k == 16) check("t6_err", rd_err, 3'b010);
        end
        tick();
        check("t6_err_pulse", rd_err, 3'b000);
        burst_data       = 32'hBAD0_0001;
        burst_data_valid = 1'b1;
        burst_data_done  = 1'b1;
        tick();
        burst_data_valid = 1'b0;
        burst_data_done  = 1'b0;
        tick();
        check("t6_late_valid", rd_valid, 3'b000);
        check("t6_late_done", rd_done, 3'b000);
        req[REQ_PROM] = 1'b1;
        tick();
        check("t6_lat_n1", burst_rd, 1'b0);
        tick();
        check("t6_lat_n2", burst_rd, 1'b1);
        check("t6_ack", ack, 3'b100);
        req[REQ_PROM] = 1'b0;
        tick();
        send_words(3'b100, 1, 32'h7700_0001, 1'b1);
        tick();
`endif

        tick();
        tick();
        check("exp_q_drained", exp_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
